// File: rtl/shift_sequencer.sv
// shift_sequencer: loads a byte into an 8-bit shift register and streams it out serially.
module shift_sequencer #(
  parameter int unsigned GAP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_dir,
  input  logic       din_fill,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] sr_i,
  output logic [1:0] sr_s,
  output logic       sr_r,
  input  logic [7:0] sr_o,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP, ST_DONE} state_t;
  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       dir_q, dir_d, fill_q, fill_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic       unused_sr_o;
  assign unused_sr_o = ^sr_o[6:1];
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    dir_d     = dir_q;
    fill_d    = fill_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: if (din_valid && din_ready) begin
        state_d   = ST_LOAD;
        data_d    = din;
        dir_d     = din_dir;
        fill_d    = din_fill;
        bit_cnt_d = 3'd0;
      end
      ST_LOAD: state_d = ST_SHIFT;
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        gap_cnt_d = 4'd0;
        state_d   = (bit_cnt_q == 3'd7) ? ST_DONE : (GAP > 0) ? ST_GAP : ST_SHIFT;
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 4'd1;
        state_d   = (gap_cnt_q == 4'(GAP - 1)) ? ST_SHIFT : ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      data_q    <= 8'd0;
      dir_q     <= 1'b0;
      fill_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      fill_q    <= fill_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
  // The outgoing bit is read straight from the register before this cycle's shift edge.
  assign din_ready = (state_q == ST_IDLE) && reset;
  assign tx_valid  = state_q == ST_SHIFT;
  assign tx_bit    = tx_valid && (dir_q ? sr_o[0] : sr_o[7]);
  assign sr_s      = (state_q == ST_LOAD) ? 2'b11 : tx_valid ? (dir_q ? 2'b10 : 2'b01) : 2'b00;
  assign sr_i      = data_q;
  assign sr_r      = fill_q;
  assign busy      = state_q != ST_IDLE;
  assign done      = state_q == ST_DONE;
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

- Upstream controller for the team's 8-bit `Shift_Register`.
- Accepts one byte per transaction over a valid/ready handshake.
- Drives the register's `i`/`s`/`r` inputs to parallel-load the byte, then shift it out one bit per step, MSB-first or LSB-first.
- Presents each outgoing bit, taken from the register's `o`, as a qualified serial stream with a completion pulse.

## Interface
- `GAP`, default 0: idle (hold, `s=00`) cycles inserted between consecutive shift steps; legal range 0–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset. Sampled on the `clk` rising edge; 0 = reset.
- `din`  in  8  byte to transmit.
- `din_dir`  in  1  0 = MSB-first (left shift, `s=01`); 1 = LSB-first (right shift, `s=10`).
- `din_fill`  in  1  serial fill bit driven on `sr_r` during shifting.
- `din_valid`  in  1  request; `din`/`din_dir`/`din_fill` are valid.
- `din_ready`  out  1  sequencer can accept a request.
- `sr_i`  out  8  parallel data to the shift register (captured byte).
- `sr_s`  out  2  mode to the shift register: 00 hold, 01 left, 10 right, 11 load.
- `sr_r`  out  1  serial input to the shift register.
- `sr_o`  in  8  shift register output.
- `tx_bit`  out  1  current outgoing bit.
- `tx_valid`  out  1  `tx_bit` is valid this cycle.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse after the last bit.

## Operation
- **States:** IDLE, LOAD, SHIFT, GAP, DONE. `sr_s`, `tx_valid`, `tx_bit`, `busy`, `done`, `din_ready` decode combinationally from state and captured registers.
- **IDLE:**
  - `din_ready` = 1 (0 while `reset` is low); `sr_s=00`.
  - On `din_valid & din_ready`, capture `din`, `din_dir`, `din_fill`, clear the bit counter, go to LOAD.
- **LOAD:** `sr_s=11`, `sr_i` = captured byte. Lasts one cycle, then SHIFT.
- **SHIFT:**
  - Outputs: `tx_valid=1`; `tx_bit = sr_o[7]` if dir=0, else `sr_o[0]`; `sr_s` = 01 (dir=0) or 10 (dir=1); `sr_r` = captured fill.
  - Increment the 3-bit counter.
  - If the counter was 7, go to DONE.
  - Otherwise go to GAP if `GAP>0`, else stay in SHIFT.
- **GAP:** `sr_s=00`, `tx_valid=0`. Hold for exactly `GAP` cycles (4-bit counter), then SHIFT.
- **DONE:** `done=1`, `sr_s=00`, `tx_valid=0`. Lasts one cycle, then IDLE.
- **Signal rules:**
  - `busy` = 1 in every state except IDLE.
  - `sr_i` always reflects the captured byte.
  - `sr_r` = captured fill in all states.
- **Input handling:**
  - `din_valid` is ignored outside IDLE; requests are never queued.
  - `din` changes after acceptance have no effect.
- **Reset:**
  - Reset low at any edge forces IDLE, clears both counters and clears the captured byte/dir/fill to 0, including mid-transaction.
  - After reset, `sr_s=00` is driven from the next cycle, so the shift register holds whatever it last contained.

## Timing
- Cycle 0 is the cycle in which `din_valid & din_ready` is sampled high.
- **GAP=0:**
  - Cycle 1: LOAD.
  - Cycles 2–9: SHIFT, bits in order (MSB-first or LSB-first).
  - Cycle 10: DONE.
  - Cycle 11: IDLE, `din_ready=1`; a new request can be accepted in cycle 11.
- **GAP=g:** bit k (k=0..7) appears in cycle 2+k·(g+1); no gap after the last bit; DONE in cycle 10+7g.
- **Bit source:** `tx_bit` in each SHIFT cycle is the register contents before that cycle's shift edge. No internal bit copy is kept; correctness relies on the register responding on the same `clk` edge.
- **Final register state:** after the transaction, the shift register holds 8 copies of the fill bit.
- **Reset values** (after a reset edge):
  - `din_ready`=1 once `reset` is high.
  - `busy`=0, `done`=0, `tx_valid`=0, `tx_bit`=0.
  - `sr_s`=00, `sr_i`=0, `sr_r`=0.

## Test plan
- **Bench setup:** instantiate `Shift_Register` as the downstream stage, and drive its own reset inactive after initialisation.
- **MSB-first:** `din=8'b11010010`, dir=0, fill=0, GAP=0.
  - `tx_bit` = 1,1,0,1,0,0,1,0 in cycles 2–9.
  - `done` in cycle 10; `sr_o`=8'h00 afterwards.
- **LSB-first with fill:** `din=8'b11010010`, dir=1, fill=1.
  - `tx_bit` = 0,1,0,0,1,0,1,1 in cycles 2–9.
  - `sr_o`=8'hFF after DONE.
- **Gap timing:** GAP=2, `din=8'hA5`, dir=0.
  - `tx_valid` high only in cycles 2,5,8,…,23, with bits 1,0,1,0,0,1,0,1.
  - `sr_s=00` in the gap cycles; `done` in cycle 24.
- **Back-to-back and ignored requests:**
  - `din_valid` held high with `8'hF0` then `8'h0F`: second acceptance in cycle 11, its first bit in cycle 13.
  - `din_valid` pulses during busy cycles 3–8 are ignored.
- **Reset mid-transaction:** `reset`=0 in cycle 5 of an `8'hA5` transfer.
  - Next cycle: `busy`=0, `tx_valid`=0, `sr_s`=00.
  - After release: `din_ready`=1, and a fresh `8'h3C` transfers correctly from cycle 0.
